ppe_param_engine: RTL and testbench
===================================

# ppe_param_engine

Clocked, parametrised successor of the partial-sum PE. It accepts 33-bit NoC packets carrying filter weights and binary ifmap rows, and computes sliding-window 1-D partial sums one tap per cycle. Each partial sum leaves as a packet addressed round-robin to the SPEs. When a row is finished and the timestep still needs rows, the block issues an input-request packet to IMEM. It sits between the router port and the PE's NoC link and uses ready/valid handshakes on both sides.

## Interface
- FILTER_SIZE, 5, taps per window (≥1, ≤ IFMAP_SIZE)
- IFMAP_SIZE, 25, bits per input row (≤25)
- WEIGHT_WIDTH, 8, signed weight width (fixed 8 in packet packing)
- SUM_WIDTH, 14, signed accumulator width; must be ≥ WEIGHT_WIDTH+$clog2(FILTER_SIZE)+1
- ROWS_PER_TS, 5, input rows per timestep
- NUM_SPE, 5, SPE destinations 0..NUM_SPE-1
- PE_ID, 0, own ID, sent as opcode of request packets
- IMEM_ID, 10, IMEM node address
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input packet valid
- in_ready  out  1  block accepts packet
- in_data  in  33  [32:29] addr, [28:25] opcode, [24:0] data
- out_valid  out  1  output packet valid
- out_ready  in  1  downstream accepts
- out_data  out  33  same packet format
- timestep  out  2  current timestep, starts at 1
- busy  out  1  state ≠ IDLE
- err_op  out  1  one-cycle pulse on unknown opcode

## Operation
- Opcodes (in_data[28:25]): 0 WEIGHT, 1 INPUT, 15 TIMESTEP_DONE. All others are dropped and pulse err_op.
- States: IDLE, ACCUM, EMIT, REQ. in_ready = alive && state==IDLE. alive is a flag set on the first edge after rst_n rises.
- WEIGHT, handled in IDLE in a single edge:
  - Bytes [7:0], [15:8], [23:16] are written to w[wptr], w[wptr+1], w[wptr+2].
  - Indices ≥ FILTER_SIZE are discarded.
  - wptr advances by 3. If the result is ≥ FILTER_SIZE, wptr wraps to 0 so the next WEIGHT packet reloads the filter.
  - State stays IDLE.
- INPUT:
  - Latch data[IFMAP_SIZE-1:0] as row r, set j=0, k=0, acc=0, go to ACCUM.
  - OUT_DIM = IFMAP_SIZE-FILTER_SIZE+1.
  - ACCUM: each cycle acc += r[j+k] ? sext(w[k]) : 0, then k++. When k==FILTER_SIZE-1, the final tap is added and the state goes to EMIT.
  - EMIT: out_data = {dest_spe[3:0], 4'd0, sext25(acc)}, out_valid=1. On handshake, dest_spe = (dest_spe+1) mod NUM_SPE.
    - If j<OUT_DIM-1: j++, k=0, acc=0, go to ACCUM.
    - Otherwise: rows++. If rows<ROWS_PER_TS go to REQ, else go to IDLE.
  - REQ: out_data = {IMEM_ID, PE_ID[3:0], 25'd0}, out_valid=1. On handshake go to IDLE.
- TIMESTEP_DONE (IDLE, one edge): rows=0, timestep++ (wraps 3→0). wptr and weights are kept.
- Arithmetic: two's complement. acc is SUM_WIDTH bits with no saturation (the parameter rule guarantees no overflow).
- dest_spe persists across rows and timesteps. Only reset clears it.

## Timing
- Reset values (asynchronous on rst_n low):
  - out_valid=0, out_data=0, in_ready=0, busy=0, err_op=0, timestep=1
  - state=IDLE, rows=0, wptr=0, dest_spe=0, weights=0
  - The first accept is possible on the second edge after rst_n rises.
- Latency:
  - From INPUT accept to the first out_valid: FILTER_SIZE+1 edges.
  - With out_ready held high, each further sum costs FILTER_SIZE+1 cycles.
- Backpressure: while out_valid && !out_ready, out_data and out_valid hold stable and no state advances.
- No new packet is accepted while busy; the upstream holds its packet.
- Reset asserted mid-ACCUM/EMIT/REQ aborts the row immediately and drops any pending packet.
- A WEIGHT packet lands after a row completes; sums already emitted keep their old weights.

## Structure
- Shared package ppe_pkg holds:
  - opcode constants OP_WEIGHT, OP_INPUT, OP_TIMESTEP_DONE
  - packet field positions and PKT_W=33
  - typedef packet_t
  - state enum
- One sub-module, ppe_weight_rf: FILTER_SIZE×8 register file with a 3-entry write port, 1 combinational read port and async clear.

## Test plan
- Load w=[1,2,3,4,5] with WEIGHT 0x030201 then 0x000504, send INPUT 0x1FFFFFF → 21 packets, each data=15, addr sequence 0,1,2,3,4,0…, then REQ {10,PE_ID,0}.
- All w=0xFF (−1), INPUT 0x000001F → sums −5,−4,−3,−2,−1 (data 0x1FFFFFB…0x1FFFFFF), then 0 for the rest.
- Hold out_ready low 10 cycles at the first EMIT → out_data stable, no dropped or duplicated packets, in_ready=0 throughout.
- Five INPUT rows → REQ after rows 1–4 only. TIMESTEP_DONE → timestep=2, next row emits REQ again.
- Opcode 7 → err_op single pulse, no output, state IDLE.
- Pull rst_n low during ACCUM of row 2 → all outputs at reset values in the same cycle; after release, the next packet accepted on the second edge.

Source files
------------

// File: rtl/ppe_pkg.sv
// ----------------------------------------------------------------------------
// ppe_pkg
// Shared definitions for the parametrised partial-sum PE: NoC packet layout,
// opcodes and FSM state encoding.
// ----------------------------------------------------------------------------
package ppe_pkg;

  localparam int PKT_W    = 33;
  localparam int DATA_W   = 25;
  localparam int ADDR_MSB = 32;
  localparam int ADDR_LSB = 29;
  localparam int OP_MSB   = 28;
  localparam int OP_LSB   = 25;
  localparam int DATA_MSB = 24;
  localparam int DATA_LSB = 0;

  localparam logic [3:0] OP_WEIGHT        = 4'd0;
  localparam logic [3:0] OP_INPUT         = 4'd1;
  localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;

  typedef struct packed {
    logic [3:0]        addr;
    logic [3:0]        op;
    logic [DATA_W-1:0] data;
  } packet_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2,
    ST_REQ   = 2'd3
  } state_e;

endpackage

// File: rtl/ppe_weight_rf.sv
// ----------------------------------------------------------------------------
// ppe_weight_rf
// FILTER_SIZE x 8-bit filter weight store. One write port that writes up to
// three consecutive entries starting at waddr_i (entries past the end of the
// filter are ignored), one combinational read port, asynchronous clear.
//
// Ports
//   clk_i    clock
//   rst_n_i  asynchronous active-low clear of all weights
//   we_i     write enable
//   waddr_i  base index of the 3-entry write
//   wdata_i  {w[base+2], w[base+1], w[base]}
//   raddr_i  read index
//   rdata_o  weight at raddr_i
// ----------------------------------------------------------------------------
module ppe_weight_rf #(
  parameter int FILTER_SIZE = 5,
  parameter int AW          = 3,
  parameter int PW          = 3
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [23:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] w_q [FILTER_SIZE];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FILTER_SIZE; i++) w_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < FILTER_SIZE; i++) begin
        for (int e = 0; e < 3; e++) begin
          if (int'(waddr_i) + e == i) w_q[i] <= wdata_i[8*e +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < FILTER_SIZE; i++) begin
      if (raddr_i == AW'(i)) rdata_o = w_q[i];
    end
  end

endmodule

// File: rtl/ppe_param_engine.sv
// ----------------------------------------------------------------------------
// ppe_param_engine
// Sliding-window 1-D partial-sum engine. Loads signed filter weights and
// binary ifmap rows from 33-bit NoC packets, computes one tap per cycle and
// emits each partial sum to the SPEs round-robin. After a row, requests the
// next row from IMEM while the timestep still needs rows.
//
// state | meaning
// IDLE  | ready for a packet (WEIGHT / INPUT / TIMESTEP_DONE)
// ACCUM | adding one tap per cycle into acc
// EMIT  | presenting the finished partial sum
// REQ   | presenting the input-request packet to IMEM
//
// Ports
//   clk, rst_n                clock, async active-low reset
//   in_valid/in_ready/in_data input packet handshake
//   out_valid/out_ready/out_data output packet handshake
//   timestep                  current timestep (resets to 1)
//   busy                      state != IDLE
//   err_op                    one-cycle pulse on an unknown opcode
// ----------------------------------------------------------------------------
module ppe_param_engine
  import ppe_pkg::*;
#(
  parameter int FILTER_SIZE  = 5,
  parameter int IFMAP_SIZE   = 25,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SUM_WIDTH    = 14,
  parameter int ROWS_PER_TS  = 5,
  parameter int NUM_SPE      = 5,
  parameter int PE_ID        = 0,
  parameter int IMEM_ID      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data,
  output logic [1:0]       timestep,
  output logic             busy,
  output logic             err_op
);

  localparam int OUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
  localparam int KW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int JW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int PW = $clog2(FILTER_SIZE + 3);
  localparam int RW = $clog2(ROWS_PER_TS + 1);
  localparam int IW = $clog2(IFMAP_SIZE + 1);

  state_e                      state_q, state_d;
  logic                        alive_q;
  logic                        err_q, err_d;
  logic [IFMAP_SIZE-1:0]       r_q, r_d;
  logic [JW-1:0]               j_q, j_d;
  logic [KW-1:0]               k_q, k_d;
  logic signed [SUM_WIDTH-1:0] acc_q, acc_d;
  logic [PW-1:0]               wptr_q, wptr_d;
  logic [RW-1:0]               rows_q, rows_d;
  logic [1:0]                  ts_q, ts_d;
  logic [3:0]                  dest_q, dest_d;

  logic                        accept;
  logic                        wr_en;
  logic [3:0]                  in_op;
  logic signed [WEIGHT_WIDTH-1:0] w_rd;
  logic signed [SUM_WIDTH-1:0] w_ext;
  logic [IW-1:0]               tap_idx;
  logic [IFMAP_SIZE-1:0]       r_sh;
  logic                        tap_bit;
  logic [DATA_W-1:0]           acc_ext;
  logic                        unused_addr;

  assign in_op       = in_data[OP_MSB:OP_LSB];
  assign unused_addr = ^in_data[ADDR_MSB:ADDR_LSB];
  assign in_ready    = alive_q && (state_q == ST_IDLE);
  assign accept      = in_valid && in_ready;

  ppe_weight_rf #(
    .FILTER_SIZE (FILTER_SIZE),
    .AW          (KW),
    .PW          (PW)
  ) u_weight_rf (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (in_data[23:0]),
    .raddr_i (k_q),
    .rdata_o (w_rd)
  );

  // Shift instead of a variable bit-select so the index width need not
  // match the row width exactly.
  assign tap_idx = IW'(j_q) + IW'(k_q);
  assign r_sh    = r_q >> tap_idx;
  assign tap_bit = r_sh[0];
  assign w_ext   = SUM_WIDTH'(w_rd);
  assign acc_ext = DATA_W'(acc_q);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    r_d     = r_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    wptr_d  = wptr_q;
    rows_d  = rows_q;
    ts_d    = ts_q;
    dest_d  = dest_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (in_op)
            OP_WEIGHT: begin
              wr_en = 1'b1;
              // Wrap once the filter is full so the next WEIGHT reloads it.
              if (int'(wptr_q) + 3 >= FILTER_SIZE) wptr_d = '0;
              else                                  wptr_d = wptr_q + PW'(3);
            end
            OP_INPUT: begin
              r_d     = in_data[IFMAP_SIZE-1:0];
              j_d     = '0;
              k_d     = '0;
              acc_d   = '0;
              state_d = ST_ACCUM;
            end
            OP_TIMESTEP_DONE: begin
              rows_d = '0;
              ts_d   = ts_q + 2'd1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + (tap_bit ? w_ext : SUM_WIDTH'(0));
        if (k_q == KW'(FILTER_SIZE - 1)) state_d = ST_EMIT;
        else                             k_d     = k_q + KW'(1);
      end
      ST_EMIT: begin
        if (out_ready) begin
          dest_d = (dest_q == 4'(NUM_SPE - 1)) ? 4'd0 : dest_q + 4'd1;
          if (j_q < JW'(OUT_DIM - 1)) begin
            j_d     = j_q + JW'(1);
            k_d     = '0;
            acc_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            // Saturate so extra rows without TIMESTEP_DONE never wrap into REQ.
            if (rows_q < RW'(ROWS_PER_TS)) rows_d = rows_q + RW'(1);
            state_d = (int'(rows_q) + 1 < ROWS_PER_TS) ? ST_REQ : ST_IDLE;
          end
        end
      end
      ST_REQ: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      alive_q <= 1'b0;
      err_q   <= 1'b0;
      r_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      wptr_q  <= '0;
      rows_q  <= '0;
      ts_q    <= 2'd1;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      err_q   <= err_d;
      r_q     <= r_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      wptr_q  <= wptr_d;
      rows_q  <= rows_d;
      ts_q    <= ts_d;
      dest_q  <= dest_d;
    end
  end

  // Outputs decode straight from state so reset clears them in the same cycle.
  always_comb begin
    out_data = '0;
    unique case (state_q)
      ST_EMIT: begin
        out_data[ADDR_MSB:ADDR_LSB] = dest_q;
        out_data[OP_MSB:OP_LSB]     = 4'd0;
        out_data[DATA_MSB:DATA_LSB] = acc_ext;
      end
      ST_REQ: begin
        out_data[ADDR_MSB:ADDR_LSB] = 4'(IMEM_ID);
        out_data[OP_MSB:OP_LSB]     = 4'(PE_ID);
      end
      default: out_data = '0;
    endcase
  end

  assign out_valid = (state_q == ST_EMIT) || (state_q == ST_REQ);
  assign busy      = (state_q != ST_IDLE);
  assign err_op    = err_q;
  assign timestep  = ts_q;

endmodule

// File: tb/tb_ppe_param_engine.sv
module tb_ppe_param_engine;
  import ppe_pkg::*;

  localparam int OUT_DIM = 21;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [32:0] out_data;
  logic [1:0]  timestep;
  logic        busy;
  logic        err_op;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] sb_exp;
  int          exp_dest = 0;
  int          sums [OUT_DIM];
  int          lat;

  always #5 clk = ~clk;

  ppe_param_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .timestep  (timestep),
    .busy      (busy),
    .err_op    (err_op)
  );

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Queue one row's sums (from the hand-filled sums[] table) plus an optional REQ.
  task automatic push_row(input bit with_req);
    for (int j = 0; j < OUT_DIM; j++) begin
      exp_q.push_back({4'(exp_dest), 4'd0, 25'(sums[j])});
      exp_dest = (exp_dest + 1) % 5;
    end
    if (with_req) exp_q.push_back({4'd10, 4'd0, 25'd0});
  endtask

  task automatic send(input logic [3:0] op, input logic [24:0] data);
    int n = 0;
    in_data  = {4'h3, op, data};
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout op=%0d in_ready=0 required=1", op);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain busy=%0b pending=%0d required busy=0 pending=0",
               name, busy, exp_q.size());
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected actual=%h required=none", out_data);
          end else begin
            sb_exp = exp_q.pop_front();
            if (out_data !== sb_exp) begin
              errors++;
              $display("FAIL sb_packet actual=%h required=%h", out_data, sb_exp);
            end
          end
        end
      end
    join_none

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err_op", err_op, 0);
    check("rst_timestep", timestep, 1);
    rst_n = 1'b1;
    #1 check("pre_alive_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("alive_in_ready", in_ready, 1);

    // Row 1: w=[1,2,3,4,5], all-ones row -> every sum 15
    send(OP_WEIGHT, 25'h030201);
    send(OP_WEIGHT, 25'h000504);
    for (int j = 0; j < OUT_DIM; j++) sums[j] = 15;
    push_row(1'b1);
    send(OP_INPUT, 25'h1FFFFFF);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("first_latency", 33'(lat), 6);
    wait_done("row1");

    // Row 2: w all -1, row 0x1F -> -5..-1 then zeros
    send(OP_WEIGHT, 25'hFFFFFF);
    send(OP_WEIGHT, 25'h00FFFF);
    for (int j = 0; j < OUT_DIM; j++) sums[j] = (j < 5) ? (j - 5) : 0;
    push_row(1'b1);
    send(OP_INPUT, 25'h000001F);
    wait_done("row2");

    // Row 3: backpressure at first EMIT; dest is 42 mod 5 = 2
    out_ready = 1'b0;
    push_row(1'b1);
    send(OP_INPUT, 25'h000001F);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    for (int c = 0; c < 10; c++) begin
      check("bp_data", out_data, {4'd2, 4'd0, 25'h1FFFFFB});
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done("row3");

    // Rows 4 and 5: only bit 24 set -> last window -1; REQ only after row 4
    for (int j = 0; j < OUT_DIM; j++) sums[j] = (j == 20) ? -1 : 0;
    push_row(1'b1);
    send(OP_INPUT, 25'h1000000);
    wait_done("row4");
    push_row(1'b0);
    send(OP_INPUT, 25'h1000000);
    wait_done("row5");
    check("ts_before_done", timestep, 1);
    send(OP_TIMESTEP_DONE, 25'd0);
    check("ts_after_done", timestep, 2);
    check("ts_done_busy", busy, 0);

    // New timestep: all-ones row with w=-1 -> every sum -5, REQ again
    for (int j = 0; j < OUT_DIM; j++) sums[j] = -5;
    push_row(1'b1);
    send(OP_INPUT, 25'h1FFFFFF);
    wait_done("ts2_row1");

    // Unknown opcode
    send(4'd7, 25'h0000123);
    check("err_pulse", err_op, 1);
    check("err_no_out", out_valid, 0);
    check("err_idle", busy, 0);
    @(posedge clk); #1;
    check("err_clear", err_op, 0);
    check("err_in_ready", in_ready, 1);

    // Reset during ACCUM of row 2 of timestep 2
    send(OP_INPUT, 25'h1FFFFFF);
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err_op", err_op, 0);
    check("mid_rst_timestep", timestep, 1);
    #2 rst_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 0);
    @(posedge clk); #1;
    check("rel_alive", in_ready, 1);

    // Weights and dest were cleared: sums 0, dest restarts at 0, REQ after row
    exp_dest = 0;
    for (int j = 0; j < OUT_DIM; j++) sums[j] = 0;
    push_row(1'b1);
    send(OP_INPUT, 25'h1FFFFFF);
    wait_done("post_rst_row");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
